// File: rtl/if_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: the NOP encoding and the
// fetch sequencer state encodings.
package if_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } if_state_e;

endpackage

// File: rtl/imem_1r1w.sv
// Instruction memory: one synchronous read port with registered data and one
// loader write port. A read to the address being written returns the old word.
module imem_1r1w #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          wen
);

  logic [31:0] mem [2**AW];

  // Contents are deliberately not reset so loader writes survive a CPU reset.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, run/idle control and NOP insertion
// in front of a 1-cycle-latency instruction memory.
//
// state | meaning
// IDLE  | not fetching; pc_if tracks start_adr, ID sees NOP
// RUN   | fetching; pc_if advances, holds on stall or jumps on redirect
module if_stage
  import if_stage_pkg::*;
#(
  parameter int IMEM_AW = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_start,
  input  logic [31:2]        start_adr,
  input  logic               jmp_purge_ex,
  input  logic [31:2]        jmp_adr_ex,
  input  logic               stall,
  input  logic               rst_pipe,
  input  logic [IMEM_AW-1:0] im_wadr,
  input  logic [31:0]        im_wdata,
  input  logic               im_wen,
  output logic [31:0]        inst_id,
  output logic [31:2]        pc_id
);

  if_state_e          state_q, state_d;
  logic [31:2]        pc_if_q, pc_if_d;
  logic [31:2]        pc_id_q;
  logic               nop_q, nop_d;
  logic               jmp_eff;
  logic               hold;
  logic [IMEM_AW-1:0] raddr;
  logic [31:0]        rdata;

  // A flush in the same cycle as a redirect wins, so the redirect is masked.
  assign jmp_eff = jmp_purge_ex & ~rst_pipe;
  assign hold    = stall & ~jmp_eff;

  // During a hold the memory re-reads the word already sitting in ID.
  assign raddr = hold ? pc_id_q[IMEM_AW+1:2] : pc_if_q[IMEM_AW+1:2];

  always_comb begin
    state_d = state_q;
    pc_if_d = pc_if_q;
    nop_d   = (state_q != RUN) | jmp_purge_ex | rst_pipe;
    if (state_q == IDLE) begin
      pc_if_d = start_adr;
      if (cpu_start) state_d = RUN;
    end else begin
      if (rst_pipe || !cpu_start) begin
        state_d = IDLE;
        pc_if_d = start_adr;
      end else if (jmp_eff) begin
        pc_if_d = jmp_adr_ex;
      end else if (!stall) begin
        pc_if_d = pc_if_q + 30'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_if_q <= '0;
      pc_id_q <= '0;
      nop_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_if_q <= pc_if_d;
      if (!hold) pc_id_q <= pc_if_q;
      nop_q   <= nop_d;
    end
  end

  imem_1r1w #(.AW(IMEM_AW)) u_imem (
    .clk   (clk),
    .raddr (raddr),
    .rdata (rdata),
    .waddr (im_wadr),
    .wdata (im_wdata),
    .wen   (im_wen)
  );

  assign inst_id = nop_q ? NOP_INST : rdata;
  assign pc_id   = pc_id_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: start, stall, redirect, write collision, flush,
// stop, address wrap and mid-run reset, with hand-computed expectations.
module tb_if_stage;

  localparam int AW = 12;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_start;
  logic [31:2]   start_adr;
  logic          jmp_purge_ex;
  logic [31:2]   jmp_adr_ex;
  logic          stall;
  logic          rst_pipe;
  logic [AW-1:0] im_wadr;
  logic [31:0]   im_wdata;
  logic          im_wen;
  logic [31:0]   inst_id;
  logic [31:2]   pc_id;

  int n_chk = 0;
  int n_err = 0;

  if_stage #(.IMEM_AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_start    (cpu_start),
    .start_adr    (start_adr),
    .jmp_purge_ex (jmp_purge_ex),
    .jmp_adr_ex   (jmp_adr_ex),
    .stall        (stall),
    .rst_pipe     (rst_pipe),
    .im_wadr      (im_wadr),
    .im_wdata     (im_wdata),
    .im_wen       (im_wen),
    .inst_id      (inst_id),
    .pc_id        (pc_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    im_wadr  = a;
    im_wdata = d;
    im_wen   = 1'b1;
    step();
    im_wen   = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] inst, input logic [31:2] pc);
    chk({tag, ".inst"}, inst_id, inst);
    chk({tag, ".pc"}, {2'b00, pc_id}, {2'b00, pc});
  endtask

  function automatic logic [31:0] wv(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  initial begin
    rst = 1'b1; cpu_start = 1'b0; start_adr = '0; jmp_purge_ex = 1'b0;
    jmp_adr_ex = '0; stall = 1'b0; rst_pipe = 1'b0;
    im_wadr = '0; im_wdata = '0; im_wen = 1'b0;
    step(); step();
    expect_out("reset", NOP, 30'h0);

    for (int i = 0; i < 8; i++) load(AW'(i), wv(i));
    load(12'h040, 32'hB000_0040);
    load(12'h041, 32'hB000_0041);
    load(12'h042, 32'hB000_0042);
    load(12'hFFF, 32'hC000_0FFF);
    rst = 1'b0;
    step();
    expect_out("idle", NOP, 30'h0);

    // start
    cpu_start = 1'b1;
    step(); expect_out("start0", NOP, 30'h0);
    step(); expect_out("start1", wv(0), 30'h0);
    step(); expect_out("start2", wv(1), 30'h1);

    // stall while B is in ID
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out($sformatf("stall%0d", i), wv(1), 30'h1);
    end
    stall = 1'b0;
    step(); expect_out("unstall", wv(2), 30'h2);
    step(); expect_out("run3", wv(3), 30'h3);

    // redirect during stall
    stall = 1'b1; jmp_purge_ex = 1'b1; jmp_adr_ex = 30'h40;
    step(); chk("jmp_nop", inst_id, NOP);
    stall = 1'b0; jmp_purge_ex = 1'b0;
    step(); expect_out("jmp_tgt", 32'hB000_0040, 30'h40);
    step(); expect_out("jmp_tgt1", 32'hB000_0041, 30'h41);

    // loader write colliding with the read of word 0x42
    im_wadr = 12'h042; im_wdata = 32'hD00D_0042; im_wen = 1'b1;
    step(); expect_out("coll_old", 32'hB000_0042, 30'h42);
    im_wen = 1'b0; stall = 1'b1;
    step(); expect_out("coll_new", 32'hD00D_0042, 30'h42);
    stall = 1'b0;

    // redirect without stall
    jmp_purge_ex = 1'b1; jmp_adr_ex = 30'h2;
    step(); chk("jmp2_nop", inst_id, NOP);
    jmp_purge_ex = 1'b0;
    step(); expect_out("jmp2_tgt", wv(2), 30'h2);

    // flush together with a redirect: flush wins, restart at start_adr
    rst_pipe = 1'b1; jmp_purge_ex = 1'b1; jmp_adr_ex = 30'h40;
    step(); chk("flush_nop", inst_id, NOP);
    rst_pipe = 1'b0; jmp_purge_ex = 1'b0;
    step(); expect_out("flush_restart", NOP, 30'h0);
    step(); expect_out("flush_a", wv(0), 30'h0);
    step(); expect_out("flush_b", wv(1), 30'h1);

    // drop run-enable
    cpu_start = 1'b0;
    step();
    step(); chk("stop_nop", inst_id, NOP);

    // wrap from the top word address
    start_adr = 30'h3FFF_FFFF;
    step();
    cpu_start = 1'b1;
    step(); expect_out("wrap0", NOP, 30'h3FFF_FFFF);
    step(); expect_out("wrap1", 32'hC000_0FFF, 30'h3FFF_FFFF);
    step(); expect_out("wrap2", wv(0), 30'h0);
    step(); expect_out("wrap3", wv(1), 30'h1);

    // reset mid-run; memory survives
    rst = 1'b1;
    step(); expect_out("rst_mid", NOP, 30'h0);
    rst = 1'b0; start_adr = '0;
    step(); expect_out("rst_restart", NOP, 30'h0);
    step(); expect_out("rst_a", wv(0), 30'h0);
    step(); expect_out("rst_b", wv(1), 30'h1);
    stall = 1'b1; jmp_purge_ex = 1'b1; jmp_adr_ex = 30'h42;
    step(); chk("rst_jmp_nop", inst_id, NOP);
    stall = 1'b0; jmp_purge_ex = 1'b0;
    step(); expect_out("rst_kept", 32'hD00D_0042, 30'h42);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
